// File: rtl/alu_op_sequencer_if.sv
// Handshake and datapath-flag bundle between main control, the ALUOp
// sequencer, and the ALU control decoder.
interface alu_op_sequencer_if;
    logic       start;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       eq_flag;
    logic       gt_flag;
    logic       lt_flag;
    logic [3:0] alu_op;
    logic       busy;
    logic       done;
    logic       branch_taken;
    logic       illegal;

    modport master (
        output start, opcode, funct, eq_flag, gt_flag, lt_flag,
        input  alu_op, busy, done, branch_taken, illegal
    );

    modport slave (
        input  start, opcode, funct, eq_flag, gt_flag, lt_flag,
        output alu_op, busy, done, branch_taken, illegal
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multicycle ALUOp issuer: decodes opcode/funct on accept, steps through one
// or two ALUOp codes, and resolves branches from the datapath compare flags.
//
// state | meaning
// IDLE  | waiting for start; decode latched on accept
// ISSUE | first ALUOp code driven
// AUX   | second code of a two-step shift
// EVAL  | branch code held while flags settle, EVAL_WAIT cycles
// DONE  | one-cycle done pulse, alu_op back to NO_OP
module alu_op_sequencer #(
    parameter int EVAL_WAIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    alu_op_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, AUX, EVAL, DONE} state_t;

    localparam logic [3:0] OP_NO   = 4'h0, OP_ADD  = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3;
    localparam logic [3:0] OP_SL1  = 4'h5, OP_SL2  = 4'h6, OP_SR  = 4'h7;
    localparam logic [3:0] OP_SRA1 = 4'h8, OP_SRA2 = 4'h9, OP_SLTI = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB, OP_BNE  = 4'hC, OP_BLE = 4'hD, OP_BGT = 4'hE;
    localparam logic [3:0] OP_LUI  = 4'hF;
    localparam logic [2:0] EVAL_CNT_INIT = 3'(EVAL_WAIT - 1);

    state_t     state, state_nxt;
    logic [3:0] first_code, second_code;
    logic       two_step, is_branch;
    logic [2:0] eval_cnt;
    logic       taken_r, illegal_r;

    logic [3:0] dec_first, dec_second;
    logic       dec_two, dec_branch, dec_illegal;
    logic       taken_now;
    logic [3:0] alu_op_c;

    always_comb begin
        dec_first   = OP_NO;
        dec_second  = OP_NO;
        dec_two     = 1'b0;
        dec_branch  = 1'b0;
        dec_illegal = 1'b0;
        case (bus.opcode)
            6'h00: begin
                case (bus.funct)
                    6'h20: dec_first = OP_ADD;
                    6'h22: dec_first = OP_SUB;
                    6'h24: dec_first = OP_AND;
                    6'h00: begin dec_first = OP_SL1;  dec_second = OP_SL2;  dec_two = 1'b1; end
                    6'h02: dec_first = OP_SR;
                    6'h03: begin dec_first = OP_SRA1; dec_second = OP_SRA2; dec_two = 1'b1; end
                    default: dec_illegal = 1'b1;
                endcase
            end
            6'h08, 6'h23, 6'h2B: dec_first = OP_ADD;
            6'h0A: dec_first = OP_SLTI;
            6'h04: begin dec_first = OP_BEQ; dec_branch = 1'b1; end
            6'h05: begin dec_first = OP_BNE; dec_branch = 1'b1; end
            6'h06: begin dec_first = OP_BLE; dec_branch = 1'b1; end
            6'h07: begin dec_first = OP_BGT; dec_branch = 1'b1; end
            6'h0F: dec_first = OP_LUI;
            default: dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        taken_now = 1'b0;
        case (first_code)
            OP_BEQ: taken_now = bus.eq_flag;
            OP_BNE: taken_now = ~bus.eq_flag;
            OP_BLE: taken_now = bus.lt_flag | bus.eq_flag;
            OP_BGT: taken_now = bus.gt_flag;
            default: taken_now = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.start) state_nxt = dec_illegal ? DONE : ISSUE;
            ISSUE: state_nxt = two_step ? AUX : (is_branch ? EVAL : DONE);
            AUX:   state_nxt = DONE;
            EVAL:  if (eval_cnt == 3'd0) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_op_c = OP_NO;
        case (state)
            ISSUE, EVAL: alu_op_c = first_code;
            AUX:         alu_op_c = second_code;
            default:     alu_op_c = OP_NO;
        endcase
    end

    assign bus.alu_op       = alu_op_c;
    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE);
    assign bus.branch_taken = taken_r;
    assign bus.illegal      = illegal_r;

    // Decode latch, EVAL down-counter and sticky result flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            first_code  <= OP_NO;
            second_code <= OP_NO;
            two_step    <= 1'b0;
            is_branch   <= 1'b0;
            eval_cnt    <= 3'd0;
            taken_r     <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    first_code  <= dec_first;
                    second_code <= dec_second;
                    two_step    <= dec_two;
                    is_branch   <= dec_branch;
                    taken_r     <= 1'b0;
                    illegal_r   <= dec_illegal;
                end
                ISSUE: if (is_branch) eval_cnt <= EVAL_CNT_INIT;
                EVAL: begin
                    if (eval_cnt == 3'd0) taken_r <= taken_now;
                    else                  eval_cnt <= eval_cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: table of decode vectors plus
// hand-written back-to-back, ignored-start and mid-operation reset sequences.
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;

    alu_op_sequencer_if bus();
    alu_op_sequencer #(.EVAL_WAIT(1)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] opc;
        logic [5:0] fn;
        logic       eq, gt, lt;
        int         lat;
        logic [3:0] op0, op1;
        logic       taken, ill;
    } vec_t;

    vec_t vecs[$];

    // Observed tuple: {alu_op, busy, done, branch_taken, illegal}
    function automatic logic [7:0] obs();
        return {bus.alu_op, bus.busy, bus.done, bus.branch_taken, bus.illegal};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got alu_op=%h busy=%b done=%b taken=%b ill=%b, want alu_op=%h busy=%b done=%b taken=%b ill=%b",
                      name, act[7:4], act[3], act[2], act[1], act[0],
                      exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    endtask

    task automatic add(input logic [5:0] opc, input logic [5:0] fn,
                       input logic eq, input logic gt, input logic lt, input int lat,
                       input logic [3:0] op0, input logic [3:0] op1,
                       input logic taken, input logic ill);
        vec_t v;
        v.opc = opc; v.fn = fn; v.eq = eq; v.gt = gt; v.lt = lt; v.lat = lat;
        v.op0 = op0; v.op1 = op1; v.taken = taken; v.ill = ill;
        vecs.push_back(v);
    endtask

    // Issues one instruction from IDLE, scrambles opcode/funct after accept,
    // checks every cycle through DONE and the following IDLE cycle.
    task automatic run_vec(input vec_t v, input string name);
        logic [3:0] eop;
        @(negedge clk);
        bus.opcode = v.opc; bus.funct = v.fn;
        bus.eq_flag = v.eq; bus.gt_flag = v.gt; bus.lt_flag = v.lt;
        bus.start = 1'b1;
        for (int k = 1; k <= v.lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b0;
                bus.opcode = 6'h3F;
                bus.funct  = 6'h3F;
            end
            if (k < v.lat) begin
                eop = (k == 1) ? v.op0 : v.op1;
                check({name, $sformatf(" c%0d", k)}, obs(), {eop, 1'b1, 1'b0, 1'b0, 1'b0});
            end else begin
                check({name, " done"}, obs(), {4'h0, 1'b1, 1'b1, v.taken, v.ill});
            end
        end
        @(negedge clk);
        check({name, " idle"}, obs(), {4'h0, 1'b0, 1'b0, v.taken, v.ill});
    endtask

    initial begin
        int f_cnt, d_cnt;
        vec_t v;
        bus.start = 1'b0; bus.opcode = 6'h00; bus.funct = 6'h00;
        bus.eq_flag = 1'b0; bus.gt_flag = 1'b0; bus.lt_flag = 1'b0;
        reset = 1'b1;

        //    opc    fn    eq gt lt lat op0   op1   tk ill
        add(6'h00, 6'h20, 0, 0, 0, 2, 4'h1, 4'h0, 0, 0);
        add(6'h00, 6'h22, 0, 0, 0, 2, 4'h2, 4'h0, 0, 0);
        add(6'h00, 6'h24, 0, 0, 0, 2, 4'h3, 4'h0, 0, 0);
        add(6'h00, 6'h00, 0, 0, 0, 3, 4'h5, 4'h6, 0, 0);
        add(6'h00, 6'h02, 0, 0, 0, 2, 4'h7, 4'h0, 0, 0);
        add(6'h00, 6'h03, 0, 0, 0, 3, 4'h8, 4'h9, 0, 0);
        add(6'h08, 6'h11, 0, 0, 0, 2, 4'h1, 4'h0, 0, 0);
        add(6'h23, 6'h00, 0, 0, 0, 2, 4'h1, 4'h0, 0, 0);
        add(6'h2B, 6'h00, 0, 0, 0, 2, 4'h1, 4'h0, 0, 0);
        add(6'h0A, 6'h00, 0, 0, 0, 2, 4'hA, 4'h0, 0, 0);
        add(6'h04, 6'h00, 1, 0, 0, 3, 4'hB, 4'hB, 1, 0);
        add(6'h04, 6'h00, 0, 1, 0, 3, 4'hB, 4'hB, 0, 0);
        add(6'h05, 6'h00, 1, 0, 0, 3, 4'hC, 4'hC, 0, 0);
        add(6'h05, 6'h00, 0, 0, 1, 3, 4'hC, 4'hC, 1, 0);
        add(6'h06, 6'h00, 1, 0, 0, 3, 4'hD, 4'hD, 1, 0);
        add(6'h06, 6'h00, 0, 1, 0, 3, 4'hD, 4'hD, 0, 0);
        add(6'h06, 6'h00, 0, 0, 1, 3, 4'hD, 4'hD, 1, 0);
        add(6'h07, 6'h00, 0, 1, 0, 3, 4'hE, 4'hE, 1, 0);
        add(6'h07, 6'h00, 1, 0, 0, 3, 4'hE, 4'hE, 0, 0);
        add(6'h0F, 6'h00, 0, 0, 0, 2, 4'hF, 4'h0, 0, 0);
        add(6'h3F, 6'h00, 0, 0, 0, 1, 4'h0, 4'h0, 0, 1);
        add(6'h08, 6'h00, 0, 0, 0, 2, 4'h1, 4'h0, 0, 0);
        add(6'h00, 6'h21, 0, 0, 0, 1, 4'h0, 4'h0, 0, 1);
        add(6'h06, 6'h00, 1, 0, 0, 3, 4'hD, 4'hD, 1, 0);
        add(6'h01, 6'h20, 0, 0, 0, 1, 4'h0, 4'h0, 0, 1);

        repeat (2) @(negedge clk);
        check("reset", obs(), 8'h00);
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Start held high: re-accepted in the IDLE cycle right after DONE.
        @(negedge clk);
        bus.opcode = 6'h08; bus.funct = 6'h00; bus.start = 1'b1;
        @(negedge clk); check("b2b c1", obs(), {4'h1, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk); check("b2b c2", obs(), {4'h0, 1'b1, 1'b1, 1'b0, 1'b0});
        @(negedge clk); check("b2b c3", obs(), {4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk); check("b2b c4", obs(), {4'h1, 1'b1, 1'b0, 1'b0, 1'b0});
        bus.start = 1'b0;
        @(negedge clk); check("b2b c5", obs(), {4'h0, 1'b1, 1'b1, 1'b0, 1'b0});
        @(negedge clk); check("b2b c6", obs(), {4'h0, 1'b0, 1'b0, 1'b0, 1'b0});

        // lui with start asserted through ISSUE and DONE.
        bus.opcode = 6'h0F; bus.start = 1'b1;
        f_cnt = 0; d_cnt = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus.alu_op == 4'hF) f_cnt++;
            if (bus.done) d_cnt++;
            if (k >= 2) bus.start = 1'b0;
        end
        check("lui f_cnt", {4'(f_cnt), 4'h0}, {4'h1, 4'h0});
        check("lui d_cnt", {4'(d_cnt), 4'h0}, {4'h1, 4'h0});

        // Reset during AUX of sll aborts with no done pulse.
        @(negedge clk);
        bus.opcode = 6'h00; bus.funct = 6'h00; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        check("rst sll c1", obs(), {4'h5, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        check("rst sll aux", obs(), {4'h6, 1'b1, 1'b0, 1'b0, 1'b0});
        reset = 1'b1;
        @(negedge clk);
        check("rst abort", obs(), 8'h00);
        reset = 1'b0;
        d_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) d_cnt++;
        end
        check("rst no done", {4'(d_cnt), 4'h0}, 8'h00);
        v = vecs[0];
        run_vec(v, "post-rst add");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multicycle issuer of the 4-bit ALUOp code consumed by the ALU control decoder. Takes a decoded instruction (opcode/funct) from the main control unit and steps through the ALUOp codes the instruction needs: one code for simple ops, two consecutive codes for two-step shifts. For branches it waits for the datapath comparison flags and returns a resolved taken/not-taken result. It sits between the main control FSM (start/done handshake) and the ALU control decoder (alu_op).

## Interface
- EVAL_WAIT, 1: cycles spent in EVAL before branch flags are sampled; legal range 1–7.

- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request from main control; accepted only in IDLE.
- opcode  in  6  instruction opcode, sampled on accept.
- funct  in  6  R-type function field, sampled on accept.
- eq_flag  in  1  datapath A==B, valid during EVAL.
- gt_flag  in  1  datapath A>B (signed), valid during EVAL.
- lt_flag  in  1  datapath A<B (signed), valid during EVAL.
- alu_op  out  4  ALUOp code to the ALU control decoder.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- branch_taken  out  1  branch result; meaningful when done=1.
- illegal  out  1  unsupported opcode/funct; meaningful when done=1.

## Operation
- ALUOp codes: NO_OP 0, ADD 1, SUB 2, AND 3, PASS_B 4, SHIFT_L1 5, SHIFT_L2 6, SHIFT_R 7, SHIFT_RA1 8, SHIFT_RA2 9, SLTI A, BEQ B, BNE C, BLE D, BGT E, LUI F.
- Decode for opcode 0x00 (R-type), by funct:
  - 0x20 → ADD.
  - 0x22 → SUB.
  - 0x24 → AND.
  - 0x00 → SHIFT_L1 then SHIFT_L2.
  - 0x02 → SHIFT_R.
  - 0x03 → SHIFT_RA1 then SHIFT_RA2.
- Decode for other opcodes:
  - 0x08 (addi), 0x23 (lw), 0x2B (sw) → ADD.
  - 0x0A → SLTI.
  - 0x04 → BEQ.
  - 0x05 → BNE.
  - 0x06 → BLE.
  - 0x07 → BGT.
  - 0x0F → LUI.
  - Anything else → illegal.
- States: IDLE, ISSUE, AUX, EVAL, DONE.
  - IDLE: on start=1, latch the decode result and clear branch_taken and illegal. Next state is ISSUE, or DONE if the instruction is illegal.
  - ISSUE: alu_op = first code. Next state is AUX for two-step shifts, EVAL for branches, otherwise DONE.
  - AUX: alu_op = second code (SHIFT_L2 or SHIFT_RA2). Next state DONE.
  - EVAL: alu_op holds the branch code. A 3-bit counter runs EVAL_WAIT cycles. On the last cycle, set branch_taken from the flags, then go to DONE:
    - BEQ: eq.
    - BNE: !eq.
    - BLE: lt|eq.
    - BGT: gt.
  - DONE: done=1, alu_op=NO_OP. Next state IDLE.
- alu_op is NO_OP in IDLE and DONE. It is a Moore output of state plus the latched codes.
- branch_taken and illegal hold their value from DONE until the next accepted start.

## Timing
- Reset values: state IDLE, alu_op 0, busy 0, done 0, branch_taken 0, illegal 0, EVAL counter 0.
- Latency counts from the accept edge to the edge at which done=1 is first seen:
  - Single-step op: 2 cycles (ISSUE, DONE).
  - Two-step shift: 3 cycles.
  - Branch: 2+EVAL_WAIT cycles.
  - Illegal: 1 cycle.
- start while busy=1 (including the DONE cycle) is ignored and is not queued. Main control must re-assert start after done.
- opcode and funct are sampled only on the accept edge. Later changes have no effect on the operation in flight.
- Flags are sampled only on the final EVAL cycle. Flag values on earlier EVAL cycles are ignored.
- Back-to-back operation: start held high continuously is accepted again in the IDLE cycle right after DONE. The minimum period is latency+1 cycles.
- Reset has priority over everything, mid-operation included. On the next edge the block is in IDLE with all outputs at reset values, and no done pulse is generated for the aborted operation.

## Test plan
- Reset, then start with opcode 0x00, funct 0x20 → alu_op=1 for one cycle; done=1 on the second edge; alu_op=0 after; busy high for 2 cycles.
- R-type funct 0x03 (sra) → alu_op sequence 8, 9, 0; done on the third cycle; illegal=0.
- opcode 0x06 (ble), EVAL_WAIT=1, lt_flag=0, eq_flag=1 → alu_op=D for 2 cycles; done with branch_taken=1. Repeat with all flags 0 and gt=1 → branch_taken=0.
- opcode 0x3F → done on the next cycle with illegal=1 and alu_op=0. A following legal addi (0x08) → alu_op=1; illegal cleared on accept.
- start pulsed during ISSUE and DONE of an lui (0x0F) → exactly one alu_op=F cycle and one done pulse.
- reset asserted during AUX of sll (funct 0x00) → next cycle alu_op=0, busy=0, no done; a new start behaves normally.
